// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cnn_pkg
// Brief    : Shared sizing for the pooled-feature flatten stage: word width,
//            lane count, pooled positions per frame and derived widths.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_CH      = 16;
  localparam int POSITIONS   = 16;

  localparam int CH_W        = $clog2(NUM_CH);
  localparam int POS_W       = $clog2(POSITIONS);
  localparam int FRAME_WORDS = POSITIONS * NUM_CH;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/flatten_bank.sv
`default_nettype none
// ============================================================================
// Module   : flatten_bank
// Brief    : One storage bank of POSITIONS entries, each entry holding all
//            NUM_CH channel words of one pooled position. Whole-entry write,
//            single-word asynchronous read addressed by (position, channel).
// Revision : 1.0 - initial release
// ============================================================================
module flatten_bank
  import cnn_pkg::*;
(
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [POS_W-1:0]             wr_pos_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data_i,
  input  logic [POS_W-1:0]             rd_pos_i,
  input  logic [CH_W-1:0]              rd_ch_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o
);

  // Lane k of an entry lives in slice [k]; lane 0 is the least significant.
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] mem_q [POSITIONS];

  // Store a full position row; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_pos_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_pos_i][rd_ch_i];

endmodule : flatten_bank
`default_nettype wire

// File: rtl/flatten_buffer_16ch.sv
`default_nettype none
// ============================================================================
// Module   : flatten_buffer_16ch
// Brief    : Ping-pong flatten buffer. Captures 16 pooled positions of 16
//            channel words into one bank, then streams the bank out one word
//            per cycle (position-major, channel-minor) over valid/ready while
//            the other bank fills.
// Revision : 1.0 - initial release
// ============================================================================
module flatten_buffer_16ch
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [DATA_WIDTH-1:0] data_in4,
  input  logic [DATA_WIDTH-1:0] data_in5,
  input  logic [DATA_WIDTH-1:0] data_in6,
  input  logic [DATA_WIDTH-1:0] data_in7,
  input  logic [DATA_WIDTH-1:0] data_in8,
  input  logic [DATA_WIDTH-1:0] data_in9,
  input  logic [DATA_WIDTH-1:0] data_in10,
  input  logic [DATA_WIDTH-1:0] data_in11,
  input  logic [DATA_WIDTH-1:0] data_in12,
  input  logic [DATA_WIDTH-1:0] data_in13,
  input  logic [DATA_WIDTH-1:0] data_in14,
  input  logic [DATA_WIDTH-1:0] data_in15,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [POS_W-1:0] c_pos_last = POS_W'(POSITIONS - 1);
  localparam logic [CH_W-1:0]  c_ch_last  = CH_W'(NUM_CH - 1);

  // Write side
  logic                  wr_bank_q, wr_bank_d;
  logic [POS_W-1:0]      wr_pos_q,  wr_pos_d;
  // Read side
  logic                  rd_bank_q, rd_bank_d;
  logic [POS_W-1:0]      rd_pos_q,  rd_pos_d;
  logic [CH_W-1:0]       rd_ch_q,   rd_ch_d;
  // Shared bank ownership
  logic [1:0]            bank_full_q, bank_full_d;
  // Output register
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q,  last_out_d;
  logic                  overflow_q,  overflow_d;

  logic [NUM_CH*DATA_WIDTH-1:0] wr_row;
  logic [1:0]                   bank_wr_en;
  logic [DATA_WIDTH-1:0]        bank_rd_data [2];
  logic [DATA_WIDTH-1:0]        rd_word;
  logic                         wr_full;
  logic                         capture;
  logic                         drop;
  logic                         wr_wrap;
  logic                         load;
  logic                         rd_last;

  assign wr_row = {data_in15, data_in14, data_in13, data_in12,
                   data_in11, data_in10, data_in9,  data_in8,
                   data_in7,  data_in6,  data_in5,  data_in4,
                   data_in3,  data_in2,  data_in1,  data_in0};

  // A beat is accepted only into a bank that is not still awaiting drain;
  // the decision uses the pre-edge flag so a same-edge release cannot help.
  assign wr_full = bank_full_q[wr_bank_q];
  assign capture = valid_in && !wr_full;
  assign drop    = valid_in &&  wr_full;
  assign wr_wrap = (wr_pos_q == c_pos_last);

  // Refill the output register whenever it is empty or being consumed.
  assign load    = bank_full_q[rd_bank_q] && (!valid_out_q || ready_in);
  assign rd_last = (rd_pos_q == c_pos_last) && (rd_ch_q == c_ch_last);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = capture && (wr_bank_q == 1'(b));

    flatten_bank u_bank (
      .clk       (clk),
      .wr_en_i   (bank_wr_en[b]),
      .wr_pos_i  (wr_pos_q),
      .wr_data_i (wr_row),
      .rd_pos_i  (rd_pos_q),
      .rd_ch_i   (rd_ch_q),
      .rd_data_o (bank_rd_data[b])
    );
  end

  assign rd_word = bank_rd_data[rd_bank_q];

  // Next-state: capture and drain touch different banks, so their updates
  // to bank_full never collide.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_pos_d    = wr_pos_q;
    rd_bank_d   = rd_bank_q;
    rd_pos_d    = rd_pos_q;
    rd_ch_d     = rd_ch_q;
    bank_full_d = bank_full_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    overflow_d  = overflow_q | drop;

    if (capture) begin
      if (wr_wrap) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_pos_d               = '0;
      end else begin
        wr_pos_d = wr_pos_q + 1'b1;
      end
    end

    if (load) begin
      data_out_d  = rd_word;
      valid_out_d = 1'b1;
      last_out_d  = rd_last;
      if (rd_last) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
        rd_pos_d               = '0;
        rd_ch_d                = '0;
      end else if (rd_ch_q == c_ch_last) begin
        rd_ch_d  = '0;
        rd_pos_d = rd_pos_q + 1'b1;
      end else begin
        rd_ch_d = rd_ch_q + 1'b1;
      end
    end else if (valid_out_q && ready_in) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end
  end

  // State and output registers; reset discards any partial or pending frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_bank_q   <= 1'b0;
      wr_pos_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_pos_q    <= '0;
      rd_ch_q     <= '0;
      bank_full_q <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_pos_q    <= wr_pos_d;
      rd_bank_q   <= rd_bank_d;
      rd_pos_q    <= rd_pos_d;
      rd_ch_q     <= rd_ch_d;
      bank_full_q <= bank_full_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign overflow  = overflow_q;
  assign busy      = (|bank_full_q) || valid_out_q;

endmodule : flatten_buffer_16ch
`default_nettype wire
